// File: rtl/tomasulo_reservation_station.sv
// Reservation station: holds dispatched instructions until both operands are
// available (captured from the CDB), then issues the lowest-index ready entry.
module tomasulo_reservation_station #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int TAG_W = 3,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [1:0]       in_busy,
  input  logic [W-1:0]     in_src0,
  input  logic [W-1:0]     in_src1,
  output logic             full_r,
  input  logic             cdb_vld,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [W-1:0]     cdb_wdata,
  output logic             iss_vld_r,
  output logic [OP_W-1:0]  iss_op_r,
  output logic [TAG_W-1:0] iss_tag_r,
  output logic [W-1:0]     iss_a_r,
  output logic [W-1:0]     iss_b_r,
  input  logic             iss_rdy
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     ent_vld;
  logic [OP_W-1:0]  ent_op   [N];
  logic [TAG_W-1:0] ent_tag  [N];
  logic [1:0]       ent_busy [N];
  logic [TAG_W-1:0] src_tag  [N][2];
  logic [W-1:0]     src_val  [N][2];
  logic [CNT_W-1:0] occ;

  logic             any_free, any_rdy, disp, load;
  logic [IDX_W-1:0] free_idx, rdy_idx;
  logic [N-1:0]     ent_vld_next;
  logic [CNT_W-1:0] occ_next;
  logic [W-1:0]     in_src [2];
  logic [1:0]       new_busy;
  logic [W-1:0]     new_val [2];

  assign in_src[0] = in_src0;
  assign in_src[1] = in_src1;

  // Priority pick of lowest free slot and lowest ready slot from registered state.
  always_comb begin
    any_free = 1'b0;
    any_rdy  = 1'b0;
    free_idx = '0;
    rdy_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_vld[i] && ent_busy[i] == 2'b00) begin
        any_rdy = 1'b1;
        rdy_idx = IDX_W'(i);
      end
    end
  end

  assign disp     = in_vld && any_free;
  assign load     = (!iss_vld_r || iss_rdy) && any_rdy;
  assign occ_next = occ + CNT_W'(disp) - CNT_W'(load);

  // Same-cycle CDB bypass so a dispatched operand cannot miss its broadcast.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      new_busy[k] = in_busy[k];
      new_val[k]  = in_src[k];
      if (in_busy[k] && cdb_vld && in_src[k][TAG_W-1:0] == cdb_tag) begin
        new_busy[k] = 1'b0;
        new_val[k]  = cdb_wdata;
      end
    end
  end

  always_comb begin
    ent_vld_next = ent_vld;
    if (load) ent_vld_next[rdy_idx] = 1'b0;
    if (disp) ent_vld_next[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld   <= '0;
      occ       <= '0;
      full_r    <= 1'b0;
      iss_vld_r <= 1'b0;
    end else begin
      ent_vld <= ent_vld_next;
      occ     <= occ_next;
      full_r  <= occ_next >= CNT_W'(N - 1);
      if (load)
        iss_vld_r <= 1'b1;
      else if (iss_rdy)
        iss_vld_r <= 1'b0;
    end
  end

  // Entry payload and issue register carry no reset; validity gates their use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (ent_vld[i] && ent_busy[i][k] && cdb_vld && src_tag[i][k] == cdb_tag) begin
          ent_busy[i][k] <= 1'b0;
          src_val[i][k]  <= cdb_wdata;
        end
      end
    end
    if (disp) begin
      ent_op[free_idx]     <= in_op;
      ent_tag[free_idx]    <= in_tag;
      ent_busy[free_idx]   <= new_busy;
      src_tag[free_idx][0] <= in_src0[TAG_W-1:0];
      src_tag[free_idx][1] <= in_src1[TAG_W-1:0];
      src_val[free_idx][0] <= new_val[0];
      src_val[free_idx][1] <= new_val[1];
    end
    if (load) begin
      iss_op_r  <= ent_op[rdy_idx];
      iss_tag_r <= ent_tag[rdy_idx];
      iss_a_r   <= src_val[rdy_idx][0];
      iss_b_r   <= src_val[rdy_idx][1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(in_vld && occ == CNT_W'(N)))
    else $error("dispatch into a full reservation station");

endmodule

// File: tb/tb_tomasulo_reservation_station.sv
// Bench for tomasulo_reservation_station: vector table plus directed sequences,
// with issued instructions checked against a queue of expected results.
module tb_tomasulo_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [3:0]  in_op;
  logic [2:0]  in_tag;
  logic [1:0]  in_busy;
  logic [31:0] in_src0, in_src1;
  logic        full_r;
  logic        cdb_vld;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_wdata;
  logic        iss_vld_r;
  logic [3:0]  iss_op_r;
  logic [2:0]  iss_tag_r;
  logic [31:0] iss_a_r, iss_b_r;
  logic        iss_rdy;

  tomasulo_reservation_station dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_op(in_op), .in_tag(in_tag), .in_busy(in_busy),
    .in_src0(in_src0), .in_src1(in_src1), .full_r(full_r),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .iss_vld_r(iss_vld_r), .iss_op_r(iss_op_r), .iss_tag_r(iss_tag_r),
    .iss_a_r(iss_a_r), .iss_b_r(iss_b_r), .iss_rdy(iss_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  tag;
    logic [31:0] a, b;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  tag;
    logic [1:0]  busy;
    logic [31:0] s0, s1;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic [31:0] ea, eb;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [2:0] tag, input logic [1:0] busy,
                          input logic [31:0] s0, input logic [31:0] s1);
    in_vld = 1'b1; in_op = op; in_tag = tag; in_busy = busy; in_src0 = s0; in_src1 = s1;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [2:0] tag, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    e.op = op; e.tag = tag; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && q.size() != 0; c++) tick();
    chk("drain_pending", q.size(), 0);
  endtask

  // Scoreboard: an accepted issue is the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && iss_vld_r && iss_rdy) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_issue: got tag %0h expected no issue", iss_tag_r);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_op", iss_op_r, e.op);
        chk("sb_tag", iss_tag_r, e.tag);
        chk("sb_a", iss_a_r, e.a);
        chk("sb_b", iss_b_r, e.b);
      end
    end
  end

  initial begin
    vecs[0] = '{4'd3, 3'd2, 2'b00, 32'd5,        32'd7,        1'b0, 3'd0, 32'h0,     32'd5,        32'd7};
    vecs[1] = '{4'd1, 3'd0, 2'b10, 32'h22,       32'd1,        1'b1, 3'd1, 32'h10,    32'h22,       32'h10};
    vecs[2] = '{4'd9, 3'd3, 2'b01, 32'd6,        32'd3,        1'b1, 3'd6, 32'hABCD,  32'hABCD,     32'd3};
    vecs[3] = '{4'd5, 3'd7, 2'b11, 32'd5,        32'd5,        1'b1, 3'd5, 32'h77,    32'h77,       32'h77};
    vecs[4] = '{4'd2, 3'd4, 2'b00, 32'd4,        32'd4,        1'b1, 3'd4, 32'hDEAD,  32'd4,        32'd4};
    vecs[5] = '{4'hF, 3'd6, 2'b00, 32'hFFFFFFFF, 32'h80000000, 1'b0, 3'd0, 32'h0,     32'hFFFFFFFF, 32'h80000000};

    rst = 1'b1; in_vld = 1'b0; in_op = '0; in_tag = '0; in_busy = '0;
    in_src0 = '0; in_src1 = '0; cdb_vld = 1'b0; cdb_tag = '0; cdb_wdata = '0; iss_rdy = 1'b0;
    tick(); tick();
    chk("reset_iss_vld", iss_vld_r, 0);
    chk("reset_full", full_r, 0);
    rst = 1'b0;
    tick();

    // Ready dispatch latency
    push(4'd3, 3'd2, 32'd5, 32'd7);
    dispatch(4'd3, 3'd2, 2'b00, 32'd5, 32'd7);
    chk("lat_not_yet", iss_vld_r, 0);
    tick();
    chk("lat_vld", iss_vld_r, 1);
    chk("lat_op", iss_op_r, 3);
    chk("lat_tag", iss_tag_r, 2);
    chk("lat_a", iss_a_r, 5);
    chk("lat_b", iss_b_r, 7);
    iss_rdy = 1'b1;
    wait_drain();

    // Table of single-instruction vectors, including same-cycle bypass
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].op, vecs[i].tag, vecs[i].ea, vecs[i].eb);
      cdb_vld = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_wdata = vecs[i].cd;
      dispatch(vecs[i].op, vecs[i].tag, vecs[i].busy, vecs[i].s0, vecs[i].s1);
      cdb_vld = 1'b0;
      wait_drain();
    end

    // Wakeup two cycles after dispatch
    push(4'd1, 3'd3, 32'h99, 32'h11);
    dispatch(4'd1, 3'd3, 2'b01, 32'd4, 32'h11);
    chk("wk_wait0", iss_vld_r, 0);
    tick();
    chk("wk_wait1", iss_vld_r, 0);
    cdb_vld = 1'b1; cdb_tag = 3'd4; cdb_wdata = 32'h99;
    tick();
    cdb_vld = 1'b0;
    chk("wk_not_same_cycle", iss_vld_r, 0);
    tick();
    chk("wk_vld", iss_vld_r, 1);
    chk("wk_a", iss_a_r, 32'h99);
    wait_drain();

    // Fill with non-ready entries, skid slot accepts the fourth
    iss_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatch(4'(i), 3'(i), 2'b01, 32'd7, 32'h40 + 32'(i));
      chk($sformatf("fill_full_%0d", i), full_r, (i >= 2) ? 1 : 0);
      push(4'(i), 3'(i), 32'h5A, 32'h40 + 32'(i));
    end
    chk("fill_no_issue", iss_vld_r, 0);
    cdb_vld = 1'b1; cdb_tag = 3'd7; cdb_wdata = 32'h5A;
    tick();
    cdb_vld = 1'b0;
    iss_rdy = 1'b1;
    wait_drain();
    chk("fill_full_after_drain", full_r, 0);

    // Stall: issue register holds while the second ready entry waits
    iss_rdy = 1'b0;
    push(4'd2, 3'd1, 32'h100, 32'd1);
    push(4'd4, 3'd5, 32'h200, 32'd2);
    dispatch(4'd2, 3'd1, 2'b00, 32'h100, 32'd1);
    dispatch(4'd4, 3'd5, 2'b00, 32'h200, 32'd2);
    for (int c = 0; c < 3; c++) begin
      chk("stall_vld", iss_vld_r, 1);
      chk("stall_tag", iss_tag_r, 1);
      chk("stall_a", iss_a_r, 32'h100);
      tick();
    end
    iss_rdy = 1'b1;
    tick();
    chk("stall_next_vld", iss_vld_r, 1);
    chk("stall_next_tag", iss_tag_r, 5);
    chk("stall_next_a", iss_a_r, 32'h200);
    wait_drain();

    // Reset with three valid entries and a pending issue
    iss_rdy = 1'b0;
    for (int i = 0; i < 4; i++) dispatch(4'd8, 3'(i), 2'b00, 32'(i), 32'd0);
    chk("pre_rst_vld", iss_vld_r, 1);
    chk("pre_rst_full", full_r, 1);
    chk("pre_rst_tag", iss_tag_r, 0);
    rst = 1'b1;
    tick();
    chk("rst_iss_vld", iss_vld_r, 0);
    chk("rst_full", full_r, 0);
    rst = 1'b0;
    iss_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst_no_stale", iss_vld_r, 0);
    end
    push(4'd6, 3'd6, 32'h1234, 32'h5678);
    dispatch(4'd6, 3'd6, 2'b00, 32'h1234, 32'h5678);
    wait_drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tomasulo_reservation_station.md
TOMASULO_RESERVATION_STATION -- requirements
Module: tomasulo_reservation_station

Interface
REQ-001 Parameter N, default 4: number of station entries, N >= 2.
REQ-002 Parameter W, default 32: operand/result word width.
REQ-003 Parameter TAG_W, default 3: producer tag width.
REQ-004 Parameter OP_W, default 4: opcode width.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_vld  in  1  dispatch valid, one instruction per cycle.
REQ-008 in_op  in  OP_W  opcode.
REQ-009 in_tag  in  TAG_W  destination tag of the instruction.
REQ-010 in_busy  in  2  per-operand pending flag; bit k = operand k awaits a producer.
REQ-011 in_src0 / in_src1  in  W each  operand value; when in_busy[k]=1, bits [TAG_W-1:0] = producer tag.
REQ-012 full_r  out  1  registered back-pressure to the dispatcher.
REQ-013 cdb_vld / cdb_tag / cdb_wdata  in  1 / TAG_W / W  registered common data bus broadcast.
REQ-014 iss_vld_r  out  1  issue valid to the execution unit.
REQ-015 iss_op_r / iss_tag_r / iss_a_r / iss_b_r  out  OP_W / TAG_W / W / W  issued instruction.
REQ-016 iss_rdy  in  1  execution unit accepts the issue-register contents this cycle.

Function
REQ-017 Each entry holds: valid, op, tag, and per operand k: busy, tag, value.
REQ-018 On in_vld, write the instruction into the lowest-index invalid entry at the next edge.
REQ-019 Dispatch and issue of the same entry index in one cycle is legal.
REQ-020 Wakeup: for each valid entry and operand with busy=1 and tag == cdb_tag while cdb_vld=1, capture cdb_wdata and clear busy.
REQ-021 Bypass: if an incoming operand has in_busy[k]=1 and in_src tag == cdb_tag while cdb_vld=1, it is written as ready with value cdb_wdata.
REQ-022 An entry is ready when valid and both busy bits are 0, evaluated on registered state only.
REQ-023 A wakeup in cycle t makes the entry eligible for issue in cycle t+1 at the earliest.
REQ-024 Issue register loads when (!iss_vld_r || iss_rdy) and any entry is ready.
REQ-025 When the issue register loads, select the lowest-index ready entry, copy it out, and invalidate it at the same edge.
REQ-026 iss_vld_r and the iss_* fields hold stable while iss_vld_r=1 and iss_rdy=0.
REQ-027 If iss_rdy=1 and no entry is ready, clear iss_vld_r next cycle.
REQ-028 Load-to-issue latency: a fully ready dispatch at edge e produces iss_vld_r=1 after edge e+1, given an empty issue register.
REQ-029 occ = count of valid entries; occ_next = occ + dispatch - issue-load.
REQ-030 full_r <= (occ_next >= N-1), giving one entry of skid for the dispatcher's registered dispatch-valid.
REQ-031 in_vld while occ == N is a protocol violation and shall be flagged by an assertion; state is unchanged.
REQ-032 Simultaneous dispatch, wakeup, and issue in one cycle are all honoured independently.

Reset
REQ-033 rst clears all entry valid bits, iss_vld_r=0, and full_r=0; data fields need not be reset.
REQ-034 rst asserted mid-operation discards all entries and any pending issue at the next edge.

Verification
REQ-035 Ready dispatch: in_op=3, in_tag=2, src0=5, src1=7, not busy -> one cycle later iss_vld_r=1, iss_a_r=5, iss_b_r=7, iss_tag_r=2.
REQ-036 Wakeup: dispatch src0 busy on tag 4; cdb_vld, tag 4, data 0x99 two cycles later -> issue the following cycle with iss_a_r=0x99.
REQ-037 Bypass: dispatch src1 busy on tag 1 in the same cycle as cdb tag 1, data 0x10 -> issue next cycle with iss_b_r=0x10.
REQ-038 Fill with iss_rdy=0, N=4, three dispatches, all non-ready -> full_r=1 after the third write; a fourth in-flight dispatch is accepted; no overflow assertion fires.
REQ-039 Stall: hold iss_rdy=0 for 3 cycles with 2 ready entries -> iss_* stable; iss_rdy=1 -> lower-index entry consumed, second entry issued next cycle.
REQ-040 Reset with 3 valid entries and iss_vld_r=1 -> next cycle iss_vld_r=0, full_r=0, and no later issue of stale entries.
